// File: rtl/rooth_defines.sv
// Shared pipeline definitions: hazard-unit flow commands and the NOP bubble encoding.
package rooth_defines;

   localparam int FLOW_WIDTH = 2;

   typedef enum logic [FLOW_WIDTH-1:0] {
      FLOW_WORK    = 2'b00,
      FLOW_STOP    = 2'b01,
      FLOW_REFRESH = 2'b10
   } flow_e;

   // addi x0, x0, 0
   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   // The reserved encoding 2'b11 is treated as a refresh, so only the MSB matters.
   function automatic logic is_refresh(input logic [FLOW_WIDTH-1:0] f);
      return f[FLOW_WIDTH-1];
   endfunction

endpackage

// File: rtl/pipe_flow_ptr.sv
// Queue pointer that advances on inc and wraps from DEPTH-1 back to 0.
module pipe_flow_ptr #(
   parameter int DEPTH = 2,
   parameter int PTR_W = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [PTR_W-1:0] ptr
);

   always_ff @(posedge clk) begin
      if (rst || clr)
         ptr <= '0;
      else if (inc)
         ptr <= (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
   end

endmodule

// File: rtl/pipe_flow_buf.sv
// Elastic pipeline-stage buffer: DEPTH-entry queue with valid/ready on both sides,
// gated by the hazard unit's work/stop/refresh command; reports what a refresh dropped.
module pipe_flow_buf
   import rooth_defines::*;
#(
   parameter int                DATA_W     = 32,
   parameter int                DEPTH      = 2,
   parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
   parameter int                CNT_W      = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [FLOW_WIDTH-1:0] flow_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic [DATA_W-1:0]     in_data_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [DATA_W-1:0]     out_data_o,
   output logic [CNT_W-1:0]      count_o,
   output logic                  full_o,
   output logic                  empty_o,
   output logic                  drop_vld_o,
   output logic [CNT_W-1:0]      drop_cnt_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic              flow_work, flow_refresh;
   logic              push, pop;

   assign flow_work    = (flow_i == FLOW_WORK);
   assign flow_refresh = is_refresh(flow_i);

   assign full_o  = (count_o == CNT_W'(DEPTH));
   assign empty_o = (count_o == '0);

   // Gating with rst keeps the handshakes closed while reset is asserted.
   assign in_ready_o  = flow_work & ~full_o & ~rst;
   assign out_valid_o = flow_work & ~empty_o & ~rst;
   assign out_data_o  = empty_o ? BUBBLE_VAL : mem[rd_ptr];

   assign push = in_valid_i & in_ready_o;
   assign pop  = out_valid_o & out_ready_i;

   pipe_flow_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_ptr (
      .clk (clk),
      .rst (rst),
      .clr (flow_refresh),
      .inc (push),
      .ptr (wr_ptr)
   );

   pipe_flow_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_ptr (
      .clk (clk),
      .rst (rst),
      .clr (flow_refresh),
      .inc (pop),
      .ptr (rd_ptr)
   );

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= in_data_i;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_o    <= '0;
         drop_vld_o <= 1'b0;
         drop_cnt_o <= '0;
      end else if (flow_refresh) begin
         count_o    <= '0;
         drop_vld_o <= (count_o != '0);
         drop_cnt_o <= count_o;
      end else begin
         drop_vld_o <= 1'b0;
         drop_cnt_o <= '0;
         if (push && !pop)
            count_o <= count_o + CNT_W'(1);
         else if (pop && !push)
            count_o <= count_o - CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_flow_buf.sv
// Directed bench for pipe_flow_buf: a DEPTH=2 and a DEPTH=3 instance share one stimulus bus.
module tb_pipe_flow_buf;
   import rooth_defines::*;

   localparam logic [31:0] BUB = NOP_INST;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  flow;
   logic        in_valid, out_ready;
   logic [31:0] in_data;

   logic        in_ready2, out_valid2, full2, empty2, drop_vld2;
   logic [31:0] out_data2;
   logic [1:0]  count2, drop_cnt2;
   logic        in_ready3, out_valid3, full3, empty3, drop_vld3;
   logic [31:0] out_data3;
   logic [1:0]  count3, drop_cnt3;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   pipe_flow_buf #(.DATA_W(32), .DEPTH(2), .BUBBLE_VAL(NOP_INST)) u_dut2 (
      .clk(clk), .rst(rst), .flow_i(flow),
      .in_valid_i(in_valid), .in_ready_o(in_ready2), .in_data_i(in_data),
      .out_valid_o(out_valid2), .out_ready_i(out_ready), .out_data_o(out_data2),
      .count_o(count2), .full_o(full2), .empty_o(empty2),
      .drop_vld_o(drop_vld2), .drop_cnt_o(drop_cnt2)
   );

   pipe_flow_buf #(.DATA_W(32), .DEPTH(3), .BUBBLE_VAL(NOP_INST)) u_dut3 (
      .clk(clk), .rst(rst), .flow_i(flow),
      .in_valid_i(in_valid), .in_ready_o(in_ready3), .in_data_i(in_data),
      .out_valid_o(out_valid3), .out_ready_i(out_ready), .out_data_o(out_data3),
      .count_o(count3), .full_o(full3), .empty_o(empty3),
      .drop_vld_o(drop_vld3), .drop_cnt_o(drop_cnt3)
   );

   // Advance one edge; inputs are then driven, and outputs checked after a further #1.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; flow = FLOW_WORK; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      tick();
      tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; flow = FLOW_WORK; in_valid = 1'b1; out_ready = 1'b1; in_data = 32'hdead;
      tick();
      tick();
      #1;
      tests++; if (in_ready2 !== 1'b0) begin fails++; $display("FAIL rst_in_ready got %b want 0", in_ready2); end
      tests++; if (count2 !== 2'd0) begin fails++; $display("FAIL rst_count got %0d want 0", count2); end
      tests++; if (empty2 !== 1'b1 || full2 !== 1'b0) begin fails++; $display("FAIL rst_flags got e%b f%b want e1 f0", empty2, full2); end
      tests++; if (out_valid2 !== 1'b0 || out_data2 !== BUB) begin fails++; $display("FAIL rst_out got v%b %h want v0 %h", out_valid2, out_data2, BUB); end
      tests++; if (drop_vld2 !== 1'b0 || drop_cnt2 !== 2'd0) begin fails++; $display("FAIL rst_drop got %b/%0d want 0/0", drop_vld2, drop_cnt2); end
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      #1;
   endtask

   task automatic test_stream();
      logic [31:0] vals [3];
      vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
      out_ready = 1'b1; in_valid = 1'b1; in_data = vals[0];
      #1;
      tests++; if (in_ready2 !== 1'b1 || out_valid2 !== 1'b0) begin fails++; $display("FAIL stream_first got r%b v%b want r1 v0", in_ready2, out_valid2); end
      for (int i = 0; i < 3; i++) begin
         tick();
         if (i < 2) in_data = vals[i+1]; else in_valid = 1'b0;
         #1;
         tests++; if (out_valid2 !== 1'b1 || out_data2 !== vals[i] || count2 !== 2'd1) begin
            fails++; $display("FAIL stream_%0d got v%b %h c%0d want v1 %h c1", i, out_valid2, out_data2, count2, vals[i]);
         end
      end
      tick();
      tests++; if (empty2 !== 1'b1 || out_data2 !== BUB) begin fails++; $display("FAIL stream_drain got e%b %h want e1 %h", empty2, out_data2, BUB); end
      out_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h44;
      tick(); in_data = 32'h55;
      tick(); in_data = 32'h66;
      #1;
      tests++; if (in_ready2 !== 1'b0 || full2 !== 1'b1 || count2 !== 2'd2) begin fails++; $display("FAIL bp_full got r%b f%b c%0d want r0 f1 c2", in_ready2, full2, count2); end
      tick();
      tests++; if (count2 !== 2'd2 || out_data2 !== 32'h44) begin fails++; $display("FAIL bp_hold got c%0d %h want c2 44", count2, out_data2); end
      out_ready = 1'b1;
      #1;
      tests++; if (in_ready2 !== 1'b0 || out_valid2 !== 1'b1) begin fails++; $display("FAIL bp_no_pass got r%b v%b want r0 v1", in_ready2, out_valid2); end
      tick();
      tests++; if (count2 !== 2'd1 || out_data2 !== 32'h55 || in_ready2 !== 1'b1) begin fails++; $display("FAIL bp_pop1 got c%0d %h r%b want c1 55 r1", count2, out_data2, in_ready2); end
      tick();
      in_valid = 1'b0;
      #1;
      tests++; if (count2 !== 2'd1 || out_data2 !== 32'h66) begin fails++; $display("FAIL bp_third got c%0d %h want c1 66", count2, out_data2); end
      tick();
      tests++; if (empty2 !== 1'b1) begin fails++; $display("FAIL bp_empty got e%b want e1", empty2); end
      out_ready = 1'b0;
   endtask

   task automatic test_stop();
      out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h77;
      tick(); in_data = 32'h88;
      tick();
      flow = FLOW_STOP; in_data = 32'h99; out_ready = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) begin
         tests++; if (in_ready2 !== 1'b0 || out_valid2 !== 1'b0 || count2 !== 2'd2 || out_data2 !== 32'h77) begin
            fails++; $display("FAIL stop_%0d got r%b v%b c%0d %h want r0 v0 c2 77", i, in_ready2, out_valid2, count2, out_data2);
         end
         tick();
      end
      flow = FLOW_WORK; in_valid = 1'b0;
      #1;
      tests++; if (out_valid2 !== 1'b1 || out_data2 !== 32'h77) begin fails++; $display("FAIL stop_resume got v%b %h want v1 77", out_valid2, out_data2); end
      tick();
      tests++; if (out_data2 !== 32'h88 || count2 !== 2'd1) begin fails++; $display("FAIL stop_next got %h c%0d want 88 c1", out_data2, count2); end
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_refresh();
      out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hb1;
      tick(); in_data = 32'hb2;
      tick();
      in_valid = 1'b0; flow = FLOW_REFRESH;
      #1;
      tests++; if (in_ready2 !== 1'b0 || out_valid2 !== 1'b0) begin fails++; $display("FAIL ref_gate got r%b v%b want r0 v0", in_ready2, out_valid2); end
      tick();
      tests++; if (drop_vld2 !== 1'b1 || drop_cnt2 !== 2'd2) begin fails++; $display("FAIL ref_drop1 got %b/%0d want 1/2", drop_vld2, drop_cnt2); end
      tests++; if (count2 !== 2'd0 || out_data2 !== BUB) begin fails++; $display("FAIL ref_clear got c%0d %h want c0 %h", count2, out_data2, BUB); end
      tick();
      tests++; if (drop_vld2 !== 1'b0) begin fails++; $display("FAIL ref_drop2 got %b want 0", drop_vld2); end
      flow = FLOW_WORK; in_valid = 1'b1; in_data = 32'hc1;
      tick();
      in_valid = 1'b0; flow = 2'b11;
      tick();
      tests++; if (drop_vld2 !== 1'b1 || drop_cnt2 !== 2'd1 || count2 !== 2'd0) begin fails++; $display("FAIL ref_rsvd got %b/%0d c%0d want 1/1 c0", drop_vld2, drop_cnt2, count2); end
      flow = FLOW_WORK;
      tick();
      tests++; if (drop_vld2 !== 1'b0) begin fails++; $display("FAIL ref_pulse got %b want 0", drop_vld2); end
   endtask

   task automatic test_wrap();
      logic [31:0] heads [7];
      logic [1:0]  cnts  [7];
      heads = '{32'ha0, 32'ha1, 32'ha1, 32'ha2, 32'ha2, 32'ha3, 32'ha3};
      cnts  = '{2'd3, 2'd2, 2'd3, 2'd2, 2'd3, 2'd2, 2'd3};
      do_reset();
      out_ready = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data = 32'ha0 + 32'(i);
         tick();
      end
      tests++; if (full3 !== 1'b1 || count3 !== 2'd3) begin fails++; $display("FAIL wrap_fill got f%b c%0d want f1 c3", full3, count3); end
      // Even steps pop, odd steps push the next payload.
      for (int i = 0; i < 7; i++) begin
         out_ready = (i % 2 == 0);
         in_valid  = (i % 2 == 1);
         in_data   = 32'ha3 + 32'(i / 2);
         #1;
         tests++; if (out_data3 !== heads[i] || count3 !== cnts[i]) begin
            fails++; $display("FAIL wrap_%0d got %h c%0d want %h c%0d", i, out_data3, count3, heads[i], cnts[i]);
         end
         tick();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      #1;
      tests++; if (out_data3 !== 32'ha4 || count3 !== 2'd2) begin fails++; $display("FAIL wrap_d0 got %h c%0d want a4 c2", out_data3, count3); end
      tick();
      tests++; if (out_data3 !== 32'ha5 || count3 !== 2'd1) begin fails++; $display("FAIL wrap_d1 got %h c%0d want a5 c1", out_data3, count3); end
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_rst_refresh();
      out_ready = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data = 32'hc0 + 32'(i);
         tick();
      end
      tests++; if (count3 !== 2'd3) begin fails++; $display("FAIL rr_fill got c%0d want c3", count3); end
      in_valid = 1'b0; rst = 1'b1; flow = FLOW_REFRESH;
      tick();
      tests++; if (count3 !== 2'd0 || drop_vld3 !== 1'b0) begin fails++; $display("FAIL rr_reset got c%0d d%b want c0 d0", count3, drop_vld3); end
      rst = 1'b0; flow = FLOW_WORK;
      #1;
      tests++; if (out_valid3 !== 1'b0 || out_data3 !== BUB) begin fails++; $display("FAIL rr_out got v%b %h want v0 %h", out_valid3, out_data3, BUB); end
      tick();
      tests++; if (drop_vld3 !== 1'b0) begin fails++; $display("FAIL rr_nodrop got %b want 0", drop_vld3); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_stop();
      test_refresh();
      test_wrap();
      test_rst_refresh();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
